// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer between the codec serializer and an external sample memory.
// Records mono left-channel samples to memory and plays them back one read per codec frame.
module audio_rec_play_ctrl #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic [1:0]        sample_end,
  input  logic [1:0]        sample_req,
  input  logic [DATA_W-1:0] audio_input,
  output logic [DATA_W-1:0] audio_output,
  output logic [1:0]        channel_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRec   = 2'd1,
    StPlay  = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] Capacity = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] One      = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic [DATA_W-1:0]   audio_q, audio_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                ack;

  // Only the left-channel strobes pace this block.
  logic unused_strobes;
  assign unused_strobes = ^{sample_end[0], sample_req[0]};

  // An ack with no request outstanding is noise from the memory side.
  assign ack = mem_ack & req_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rec_len_d = rec_len_q;
    audio_d   = audio_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (ack) begin
      req_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (stop) begin
          state_d = StIdle;
        end else if (rec_start) begin
          state_d   = StRec;
          addr_d    = '0;
          rec_len_d = '0;
          overrun_d = 1'b0;
          audio_d   = '0;
        end else if (play_start && (rec_len_q != '0)) begin
          state_d   = StPlay;
          addr_d    = '0;
          overrun_d = 1'b0;
          req_d     = 1'b1;
          we_d      = 1'b0;
          maddr_d   = '0;
        end
      end

      StRec: begin
        if (ack) begin
          addr_d    = addr_q + One;
          rec_len_d = rec_len_q + One;
        end
        if (stop) begin
          state_d = (req_q && !mem_ack) ? StDrain : StIdle;
        end else begin
          if (ack && ((rec_len_q + One) == Capacity)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          if (sample_end[1]) begin
            if (req_q) begin
              overrun_d = 1'b1;
            end else begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              maddr_d = addr_q[ADDR_W-1:0];
              wdata_d = audio_input;
            end
          end
        end
      end

      StPlay: begin
        if (ack) begin
          addr_d  = addr_q + One;
          audio_d = mem_rdata;
        end
        if (stop) begin
          state_d = (req_q && !mem_ack) ? StDrain : StIdle;
        end else begin
          if (sample_end[1]) begin
            if (req_q) begin
              overrun_d = 1'b1;
            end else if (addr_q < rec_len_q) begin
              req_d   = 1'b1;
              we_d    = 1'b0;
              maddr_d = addr_q[ADDR_W-1:0];
            end
          end
          // Last sample is already on audio_output; finish once the codec has taken it.
          if (sample_req[1] && !req_q && (addr_q == rec_len_q)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      StDrain: begin
        if (ack) begin
          state_d = StIdle;
          addr_d  = addr_q + One;
          if (we_q) begin
            rec_len_d = rec_len_q + One;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rec_len_q <= '0;
      audio_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rec_len_q <= rec_len_d;
      audio_q   <= audio_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign state        = state_q;
  assign channel_sel  = (state_q == StIdle) ? 2'b00 : 2'b10;
  assign audio_output = audio_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = wdata_q;
  assign rec_len      = rec_len_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/audio_rec_play_ctrl.md
Name: audio_rec_play_ctrl

Overview:
Record/playback sequencer between the codec serializer and an external sample memory. In RECORD it captures each left-channel sample at the codec's sample_end strobe and writes it to memory at an incrementing address. In PLAY it reads samples back in order and holds each on audio_output before the codec's sample_req strobe. Recording is mono; the codec repeats the left sample on the right channel.

Parameters:
ADDR_W, 18, memory address width; capacity is 2^ADDR_W samples.
DATA_W, 16, sample width; must match the codec sample width.

Ports:
clk  in  1  system clock, same clock as the codec.
reset  in  1  synchronous, active-high reset.
rec_start  in  1  single-cycle pulse: begin recording.
play_start  in  1  single-cycle pulse: begin playback.
stop  in  1  single-cycle pulse: end the current operation.
sample_end  in  2  codec strobe; bit1 = left sample captured.
sample_req  in  2  codec strobe; bit1 = left sample about to load.
audio_input  in  DATA_W  codec captured sample.
audio_output  out  DATA_W  sample presented to the codec.
channel_sel  out  2  codec channel enable; 1 = left, 0 = right.
mem_req  out  1  memory request; held until mem_ack.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  write data.
mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
mem_ack  in  1  one-cycle completion strobe.
state  out  2  0 IDLE, 1 REC, 2 PLAY, 3 DRAIN.
rec_len  out  ADDR_W+1  number of samples in the last recording.
done  out  1  one-cycle pulse when PLAY reaches the end or REC fills memory.
overrun  out  1  sticky: a strobe arrived while a memory request was pending.

Behaviour:
- Reset values: state = IDLE; audio_output = 0; channel_sel = 2'b00; mem_req, mem_we = 0; mem_addr, mem_wdata = 0; rec_len = 0; done = 0; overrun = 0.
- Reset mid-operation takes effect immediately and drops mem_req. The memory side must tolerate an abandoned request.
- channel_sel = 2'b10 in REC, PLAY and DRAIN; 2'b00 in IDLE.
- Command priority in the same cycle: stop > rec_start > play_start. Starts are accepted only in IDLE.
- IDLE -> REC on rec_start:
  - addr counter = 0; rec_len = 0; overrun cleared.
- IDLE -> PLAY on play_start, only if rec_len != 0:
  - addr counter = 0; overrun cleared.
  - Issue the read of address 0 on the next cycle.
- play_start with rec_len == 0 is ignored; state stays IDLE.
- Memory handshake:
  - The block asserts mem_req with addr, we and wdata, and holds all of them stable until the cycle mem_ack = 1.
  - mem_req deasserts in the cycle after the ack.
  - At most one request is outstanding.
  - mem_ack while mem_req = 0 is ignored.
- REC:
  - On sample_end[1] with no request pending: mem_wdata <= audio_input, mem_we <= 1, mem_req <= 1, mem_addr <= addr counter.
  - On ack: addr counter += 1 and rec_len += 1.
  - When rec_len reaches 2^ADDR_W: pulse done, go to IDLE. No address wrap.
  - sample_end[0] is ignored.
- PLAY:
  - Read addr counter. On ack: audio_output <= mem_rdata, addr counter += 1.
  - Issue the next read on the following sample_end[1] if addr counter < rec_len.
  - On sample_req[1] with addr counter == rec_len and no request pending: pulse done, go to IDLE. The last sample has been handed to the codec; audio_output is held until the next operation.
- Strobe while a request is pending (REC sample_end[1], or PLAY read trigger): the sample is dropped and overrun is set. The pending request completes normally.
- stop in REC or PLAY:
  - No request pending: go to IDLE next cycle.
  - Request pending: go to DRAIN; DRAIN -> IDLE on mem_ack.
  - A write acked during DRAIN still increments rec_len.
  - stop does not pulse done.
- stop in IDLE is ignored. Commands received in DRAIN are ignored.
- audio_output in REC = 0 (monitor mute). It holds its value in IDLE and DRAIN.

Test Plan:
- Record 3 samples: ADDR_W = 4; rec_start; drive audio_input 0x1111, 0x2222, 0x3333 on three sample_end[1] strobes; ack after 2 cycles; stop -> writes to addresses 0, 1, 2 with matching data; rec_len = 3; state = IDLE.
- Playback: after the recording above, play_start; memory returns the stored data -> audio_output = 0x1111, 0x2222, 0x3333, each valid before its sample_req[1]; done pulses once; rec_len unchanged.
- Memory full: ADDR_W = 2; record 4 samples -> done pulses after the 4th ack; rec_len = 4; the 5th sample_end[1] issues no request.
- Overrun: withhold mem_ack across two sample_end[1] strobes in REC -> overrun = 1; only one write issued; overrun cleared by the next rec_start.
- Stop with request pending: stop while a write is unacked -> state = DRAIN; mem_req held; ack -> state = IDLE and rec_len incremented.
- Priority and guards: stop and rec_start together in PLAY -> IDLE, not REC; play_start after reset (rec_len = 0) -> stays IDLE with no mem_req; reset mid-REC -> all outputs at reset values next cycle.
